id_ex_operand_stage: RTL
========================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-side operand forwarding for the 5-stage RV32 pipeline.
- Captures decoded operands and control from ID. Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Drives the ALU's a, b and 4-bit alu_control directly.
- Detects load-use hazards: stalls IF/ID for one cycle and inserts a bubble. Also keeps a stall counter.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID slot holds a real instruction
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_alu_control  in  4  ALU op (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR, 1000 SLL, 1001 SRL)
- id_alu_src  in  1  0 = b from rs2, 1 = b from imm
- id_reg_write, id_mem_read, id_mem_write  in  1  control
- flush  in  1  branch/jump redirect; kill the ID instruction
- mem_rd  in  5, mem_reg_write  in  1, mem_alu_result  in  XLEN  EX/MEM forwarding source
- wb_rd  in  5, wb_reg_write  in  1, wb_data  in  XLEN  MEM/WB forwarding source
- ex_a, ex_b  out  XLEN  ALU operands
- ex_alu_control  out  4  ALU op
- ex_store_data  out  XLEN  forwarded rs2 for stores
- ex_rd  out  5; ex_reg_write, ex_mem_read, ex_mem_write, ex_valid  out  1
- stall_if_id  out  1  hold PC and IF/ID this cycle
- stall_count  out  CNT_W  number of load-use stalls

Behaviour:
- Reset (async, rst_n=0): all ID/EX registers clear to 0, ex_valid=0, stall_count=0.
  - Consequently ex_a=ex_b=ex_store_data=0, ex_alu_control=0000, all ex_* controls 0, stall_if_id=0.
- rs2 usage: uses_rs2 = ~id_alu_src | id_mem_write. rs1 is always treated as used.
- Load-use (combinational): stall_if_id = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)).
- Register update, each posedge, in priority order:
  1. flush=1: bubble is loaded (valid=0, reg_write/mem_read/mem_write=0, alu_control=0000, rd=0). stall_if_id is ignored and the counter does not increment.
  2. stall_if_id=1: bubble is loaded; stall_count increments, saturating at all-ones.
  3. Otherwise: all id_* fields are captured; valid=id_valid.
- Bubble suppression: ex_reg_write, ex_mem_read, ex_mem_write are ANDed with ex_valid.
- Forwarding (combinational from registered rs1/rs2/data), for each source operand:
  - if mem_reg_write & mem_rd!=0 & mem_rd==rs → mem_alu_result (EX/MEM has priority);
  - else if wb_reg_write & wb_rd!=0 & wb_rd==rs → wb_data;
  - else the registered register-file data.
- Operand mapping:
  - ex_a = forwarded rs1.
  - ex_store_data = forwarded rs2.
  - ex_b = registered imm if alu_src=1, else forwarded rs2.
- x0 is never forwarded, so a read of x0 always returns the registered data (0 from the register file).
- Latency: ID→EX is one cycle. Forwarding adds no cycles. A load-use dependency costs exactly one bubble.
- Register file is write-first, so a same-cycle WB write is seen at ID; no extra bypass is required here.
- Reset mid-stall: stall_if_id drops immediately because ex_valid=0. The counter clears.
- Simultaneous flush and stall: flush wins, as ordered above.

Test Plan:
- Reset then deassert; drive ADD x3,x1,x2 (rs1_data=5, rs2_data=7, alu_control=0010).
  → next cycle ex_a=5, ex_b=7, ex_alu_control=0010, ex_rd=3, ex_valid=1.
- EX instruction reads rs1=x3 with mem_rd=3, mem_reg_write=1, mem_alu_result=0x20, and wb_rd=3, wb_data=0x99.
  → ex_a=0x20 (MEM priority). Remove the MEM match → ex_a=0x99.
- Load LW x4 is in EX (ex_mem_read=1, ex_rd=4); ID holds SUB x5,x4,x1.
  → stall_if_id=1 for one cycle; the next cycle ex_valid=0 and stall_count=1; SUB enters the cycle after, with WB forwarding of x4.
- Same load-use setup with flush=1 asserted in the same cycle.
  → bubble is loaded, stall_count stays 0.
- Instruction with rd=x0 producing 0xFFFF in MEM; consumer reads x0.
  → ex_a=0 (no forward). I-type ADDI with alu_src=1, imm=0xFFFFFFFC and rs2 matching ex_rd of a load → no stall; ex_b=0xFFFFFFFC.
- Force repeated load-use stalls with CNT_W=2.
  → stall_count counts 1, 2, 3, then holds at 3. Assert rst_n=0 mid-clock → all outputs 0 immediately.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and load-use hazard detection.
// Bubbles are inserted on flush or load-use stall; stalls are counted with saturation.
module id_ex_operand_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             id_valid_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic [3:0]       id_alu_control_i,
  input  logic             id_alu_src_i,
  input  logic             id_reg_write_i,
  input  logic             id_mem_read_i,
  input  logic             id_mem_write_i,
  input  logic             flush_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_reg_write_i,
  input  logic [XLEN-1:0]  mem_alu_result_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             wb_reg_write_i,
  input  logic [XLEN-1:0]  wb_data_i,
  output logic [XLEN-1:0]  ex_a_o,
  output logic [XLEN-1:0]  ex_b_o,
  output logic [3:0]       ex_alu_control_o,
  output logic [XLEN-1:0]  ex_store_data_o,
  output logic [4:0]       ex_rd_o,
  output logic             ex_reg_write_o,
  output logic             ex_mem_read_o,
  output logic             ex_mem_write_o,
  output logic             ex_valid_o,
  output logic             stall_if_id_o,
  output logic [CNT_W-1:0] stall_count_o
);

  logic             valid_q, alu_src_q, reg_write_q, mem_read_q, mem_write_q;
  logic [4:0]       rs1_q, rs2_q, rd_q;
  logic [3:0]       alu_control_q;
  logic [XLEN-1:0]  rs1_data_q, rs2_data_q, imm_q;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             uses_rs2, stall, bubble;
  logic [XLEN-1:0]  fwd_rs1, fwd_rs2;

  assign uses_rs2 = ~id_alu_src_i | id_mem_write_i;
  assign stall    = id_valid_i & valid_q & mem_read_q & (rd_q != 5'd0) &
                    ((rd_q == id_rs1_i) | (uses_rs2 & (rd_q == id_rs2_i)));
  assign bubble   = flush_i | stall;

  always_comb begin
    stall_count_d = stall_count_q;
    if (!flush_i && stall && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q       <= 1'b0;
      alu_src_q     <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      alu_control_q <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      imm_q         <= '0;
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      if (bubble) begin
        // Bubble clears operands too so a dead slot never drives stale data into the ALU.
        valid_q       <= 1'b0;
        alu_src_q     <= 1'b0;
        reg_write_q   <= 1'b0;
        mem_read_q    <= 1'b0;
        mem_write_q   <= 1'b0;
        rs1_q         <= '0;
        rs2_q         <= '0;
        rd_q          <= '0;
        alu_control_q <= '0;
        rs1_data_q    <= '0;
        rs2_data_q    <= '0;
        imm_q         <= '0;
      end else begin
        valid_q       <= id_valid_i;
        alu_src_q     <= id_alu_src_i;
        reg_write_q   <= id_reg_write_i;
        mem_read_q    <= id_mem_read_i;
        mem_write_q   <= id_mem_write_i;
        rs1_q         <= id_rs1_i;
        rs2_q         <= id_rs2_i;
        rd_q          <= id_rd_i;
        alu_control_q <= id_alu_control_i;
        rs1_data_q    <= id_rs1_data_i;
        rs2_data_q    <= id_rs2_data_i;
        imm_q         <= id_imm_i;
      end
    end
  end

  // EX/MEM wins over MEM/WB; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (mem_reg_write_i && (mem_rd_i != 5'd0) && (mem_rd_i == rs1_q)) begin
      fwd_rs1 = mem_alu_result_i;
    end else if (wb_reg_write_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs1_q)) begin
      fwd_rs1 = wb_data_i;
    end
    fwd_rs2 = rs2_data_q;
    if (mem_reg_write_i && (mem_rd_i != 5'd0) && (mem_rd_i == rs2_q)) begin
      fwd_rs2 = mem_alu_result_i;
    end else if (wb_reg_write_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs2_q)) begin
      fwd_rs2 = wb_data_i;
    end
  end

  assign ex_a_o           = fwd_rs1;
  assign ex_b_o           = alu_src_q ? imm_q : fwd_rs2;
  assign ex_store_data_o  = fwd_rs2;
  assign ex_alu_control_o = alu_control_q;
  assign ex_rd_o          = rd_q;
  assign ex_valid_o       = valid_q;
  assign ex_reg_write_o   = reg_write_q & valid_q;
  assign ex_mem_read_o    = mem_read_q & valid_q;
  assign ex_mem_write_o   = mem_write_q & valid_q;
  assign stall_if_id_o    = stall;
  assign stall_count_o    = stall_count_q;

endmodule
